// File: rtl/bsg_dff_trio.sv
// bsg_dff_trio: three independent storage lanes sharing one clock and reset.
//   plain lane  : unconditional register, one cycle of latency
//   enabled lane: register that loads only when en_i is high
//   bypass lane : enabled register whose output passes the input straight
//                 through while byp_en_i is high
module bsg_dff_trio #(
    parameter int unsigned width_p     = 1,
    parameter int unsigned reset_val_p = 0
) (
    input  logic               clk_i,
    input  logic               reset_i,

    input  logic [width_p-1:0] dff_data_i,
    output logic [width_p-1:0] dff_data_o,

    input  logic               en_i,
    input  logic [width_p-1:0] en_data_i,
    output logic [width_p-1:0] en_data_o,

    input  logic               byp_en_i,
    input  logic [width_p-1:0] byp_data_i,
    output logic [width_p-1:0] byp_data_o
);

    // Reset value truncated (or zero-extended) to the lane width.
    localparam logic [width_p-1:0] reset_val_lp = width_p'(reset_val_p);

    logic [width_p-1:0] dff_q;
    logic [width_p-1:0] en_q;
    logic [width_p-1:0] byp_q;

    // Plain lane: capture every cycle.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            dff_q <= reset_val_lp;
        end else begin
            dff_q <= dff_data_i;
        end
    end

    // Enabled lane: capture only when en_i is high, otherwise hold.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            en_q <= reset_val_lp;
        end else if (en_i) begin
            en_q <= en_data_i;
        end
    end

    // Bypass lane storage: capture when byp_en_i is high, otherwise hold.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            byp_q <= reset_val_lp;
        end else if (byp_en_i) begin
            byp_q <= byp_data_i;
        end
    end

    // Bypass output mux; deliberately not gated by reset so the live input
    // is visible in the same cycle it is presented.
    always_comb begin
        byp_data_o = byp_q;
        if (byp_en_i) begin
            byp_data_o = byp_data_i;
        end
    end

    assign dff_data_o = dff_q;
    assign en_data_o  = en_q;

endmodule

// File: tb/tb_bsg_dff_trio.sv
// Directed testbench for bsg_dff_trio: one instance with a zero reset value
// and one with reset value 0xC3, both driven from the same stimulus.
`timescale 1ns/1ps
module tb_bsg_dff_trio;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset_i;
    logic [W-1:0] dff_data_i, en_data_i, byp_data_i;
    logic         en_i, byp_en_i;

    logic [W-1:0] a_dff, a_en, a_byp;
    logic [W-1:0] b_dff, b_en, b_byp;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bsg_dff_trio #(.width_p(W), .reset_val_p(0)) dut_a (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .dff_data_i (dff_data_i),
        .dff_data_o (a_dff),
        .en_i       (en_i),
        .en_data_i  (en_data_i),
        .en_data_o  (a_en),
        .byp_en_i   (byp_en_i),
        .byp_data_i (byp_data_i),
        .byp_data_o (a_byp)
    );

    bsg_dff_trio #(.width_p(W), .reset_val_p(8'hC3)) dut_b (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .dff_data_i (dff_data_i),
        .dff_data_o (b_dff),
        .en_i       (en_i),
        .en_data_i  (en_data_i),
        .en_data_o  (b_en),
        .byp_en_i   (byp_en_i),
        .byp_data_i (byp_data_i),
        .byp_data_o (b_byp)
    );

    // Count one comparison and report it if it differs.
    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_i    = 1'b1;
        dff_data_i = '0;
        en_data_i  = '0;
        byp_data_i = '0;
        en_i       = 1'b0;
        byp_en_i   = 1'b0;

        // Reset applied before any clock edge.
        #2;
        check("rst_a_dff", a_dff, 8'h00);
        check("rst_a_en",  a_en,  8'h00);
        check("rst_a_byp", a_byp, 8'h00);
        check("rst_b_dff", b_dff, 8'hC3);
        check("rst_b_en",  b_en,  8'hC3);
        check("rst_b_byp", b_byp, 8'hC3);

        // Bypass passes through during reset.
        byp_en_i   = 1'b1;
        byp_data_i = 8'h3C;
        #1;
        check("rst_byp_pass", a_byp, 8'h3C);

        // Edge during reset must not load, whatever the enables.
        dff_data_i = 8'h77;
        en_i       = 1'b1;
        en_data_i  = 8'h77;
        step();
        check("rst_noload_dff", a_dff, 8'h00);
        check("rst_noload_en",  a_en,  8'h00);
        byp_en_i = 1'b0;
        #1;
        check("rst_noload_byp", a_byp, 8'h00);

        // Release reset between edges with quiet inputs.
        en_i       = 1'b0;
        dff_data_i = 8'h00;
        #1;
        reset_i = 1'b0;

        // Plain lane pipeline.
        dff_data_i = 8'h11; step(); check("dff_11", a_dff, 8'h11);
        dff_data_i = 8'h22; step(); check("dff_22", a_dff, 8'h22);
        dff_data_i = 8'h33; step(); check("dff_33", a_dff, 8'h33);
        check("indep_en_after_dff", a_en, 8'h00);

        // Enabled lane load then hold.
        en_i = 1'b1; en_data_i = 8'hA5;
        step();
        check("en_load", a_en, 8'hA5);
        en_i = 1'b0; en_data_i = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            step();
            check("en_hold", a_en, 8'hA5);
        end

        // Bypass lane: same-cycle pass, then hold.
        byp_en_i = 1'b1; byp_data_i = 8'h5A;
        #1;
        check("byp_pass", a_byp, 8'h5A);
        step();
        byp_en_i = 1'b0; byp_data_i = 8'h00;
        #1;
        check("byp_hold", a_byp, 8'h5A);
        dff_data_i = 8'h44;
        step();
        check("dff_44", a_dff, 8'h44);
        check("indep_en", a_en, 8'hA5);
        check("indep_byp", a_byp, 8'h5A);

        // Asynchronous reset mid-cycle with both enables high.
        en_i = 1'b1; en_data_i = 8'h11;
        byp_en_i = 1'b1; byp_data_i = 8'h22;
        dff_data_i = 8'h66;
        #1;
        reset_i = 1'b1;
        #1;
        check("mid_rst_en",  a_en,  8'h00);
        check("mid_rst_dff", a_dff, 8'h00);
        check("mid_rst_byp_pass", a_byp, 8'h22);
        step();
        check("mid_rst_noload_en",  a_en,  8'h00);
        check("mid_rst_noload_dff", a_dff, 8'h00);
        byp_en_i = 1'b0;
        #1;
        check("mid_rst_byp_reg", a_byp, 8'h00);
        check("mid_rst_b_dff", b_dff, 8'hC3);
        check("mid_rst_b_en",  b_en,  8'hC3);
        check("mid_rst_b_byp", b_byp, 8'hC3);

        // Release and confirm loads resume on the first edge.
        byp_en_i = 1'b1;
        #1;
        reset_i = 1'b0;
        step();
        byp_en_i = 1'b0;
        en_i     = 1'b0;
        #1;
        check("resume_en",  a_en,  8'h11);
        check("resume_byp", a_byp, 8'h22);
        check("resume_dff", a_dff, 8'h66);
        check("resume_b_en", b_en, 8'h11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bsg_dff_trio.md
BSG_DFF_TRIO -- requirements
Module: bsg_dff_trio

Interface
REQ-001 Parameter width_p, default 1: bit width of every data lane; SHALL be >= 1.
REQ-002 Parameter reset_val_p, default 0: value loaded into every storage register on reset, truncated to width_p bits.
REQ-003 clk_i  input  1  sole clock; all registers update on its rising edge.
REQ-004 reset_i  input  1  asynchronous, active-high reset.
REQ-005 dff_data_i  input  width_p  plain-register lane input.
REQ-006 dff_data_o  output  width_p  plain-register lane output.
REQ-007 en_i  input  1  load enable for the enabled-register lane.
REQ-008 en_data_i  input  width_p  enabled-register lane input.
REQ-009 en_data_o  output  width_p  enabled-register lane output.
REQ-010 byp_en_i  input  1  load enable for the bypass lane.
REQ-011 byp_data_i  input  width_p  bypass lane input.
REQ-012 byp_data_o  output  width_p  bypass lane output.

Function
REQ-013 The plain lane SHALL register dff_data_i on every rising clk_i when reset_i=0; dff_data_o is the register value, latency 1 cycle.
REQ-014 The enabled lane SHALL load en_data_i on a rising clk_i only when en_i=1 and reset_i=0; when en_i=0 it holds its value indefinitely; en_data_o is the register value.
REQ-015 The bypass lane SHALL load byp_data_i on a rising clk_i when byp_en_i=1 and reset_i=0, and hold it otherwise.
REQ-016 byp_data_o SHALL be combinational: byp_data_i when byp_en_i=1, else the bypass register value; zero-cycle latency on the enabled path, with no glitch-free guarantee beyond combinational settling.
REQ-017 The three lanes SHALL be fully independent; no input of one lane affects another lane's state or output.
REQ-018 The value captured at an edge SHALL be the input value present before that edge (standard setup semantics); an enable changing at the same edge as data has no effect on that edge's capture beyond its pre-edge value.
REQ-019 All data paths SHALL be bitwise; no arithmetic, no width conversion, no X-propagation from unused bits.
REQ-020 Holding an enable high for consecutive cycles SHALL load every cycle; there is no handshake or backpressure.

Reset
REQ-021 Assertion of reset_i SHALL immediately, without waiting for clk_i, set all three storage registers to reset_val_p.
REQ-022 While reset_i=1: dff_data_o = en_data_o = reset_val_p; byp_data_o = reset_val_p when byp_en_i=0, and byp_data_i when byp_en_i=1 (the combinational bypass is not gated by reset).
REQ-023 While reset_i=1, clock edges SHALL NOT load any register regardless of enables.
REQ-024 After reset_i deasserts, the first rising clk_i with reset_i=0 SHALL behave as a normal cycle per REQ-013..REQ-015.
REQ-025 Reset asserted mid-operation SHALL discard all held values; no lane retains pre-reset data.

Verification
REQ-026 width_p=8, reset_val_p=0: pulse reset_i between edges -> all outputs 0x00 before the next edge; with byp_en_i=1, byp_data_i=0x3C during reset -> byp_data_o=0x3C.
REQ-027 Plain lane: drive dff_data_i 0x11, 0x22, 0x33 on successive cycles -> dff_data_o shows 0x11, 0x22, 0x33 each one cycle later.
REQ-028 Enabled lane: en_i=1 with 0xA5 for one edge, then en_i=0 with 0xFF for 5 edges -> en_data_o stays 0xA5 throughout.
REQ-029 Bypass lane: byp_en_i=1, byp_data_i=0x5A -> byp_data_o=0x5A same cycle; after edge, byp_en_i=0, byp_data_i=0x00 -> byp_data_o=0x5A held.
REQ-030 Async reset mid-operation: lanes hold 0xA5/0x5A, assert reset_i between edges with en_i=byp_en_i=1 -> en_data_o=0x00 immediately, no load at next edge; after deassert, loads resume on first edge.
REQ-031 reset_val_p=0xC3: assert reset -> dff_data_o, en_data_o, and byp_data_o (byp_en_i=0) all read 0xC3.
